// File: rtl/fifo_frame_stream.sv
// fifo_frame_stream: turns a standard-mode (1-cycle read latency) FIFO into
// an AXI4-Stream of fixed-length frames. A 2-entry skid buffer absorbs the
// FIFO read latency and downstream back-pressure. Every C_FRAME_BEATS-th beat
// carries tlast. A stop request only takes effect at a frame boundary.
//
// Handshake: a beat transfers on a rising clk edge where m_axis_tvalid and
// m_axis_tready are both high. While tvalid is high and tready is low, tdata
// and tlast hold. tvalid only drops after a handshake.
module fifo_frame_stream #(
    parameter int C_DATA_W      = 128,
    parameter int C_FRAME_BEATS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [C_DATA_W-1:0]   fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [C_DATA_W-1:0]   m_axis_tdata,
    output logic [C_DATA_W/8-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [31:0]           frame_cnt
);

    localparam int            CW        = $clog2(C_FRAME_BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(C_FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  inflight;
    logic [1:0]            occ;
    logic [C_DATA_W-1:0]   buf0;
    logic [C_DATA_W-1:0]   buf1;
    logic [CW-1:0]         rd_beat;
    logic [CW-1:0]         out_beat;
    logic [31:0]           frame_cnt_q;
    logic                  push;
    logic                  pop;
    logic [2:0]            credit_used;
    logic                  credit_ok;

    // Data returning from the FIFO is the read issued last cycle.
    assign push = inflight;
    assign pop  = m_axis_tvalid && m_axis_tready;

    // Credit counts the slot freed by a pop in this same cycle, so that with
    // tready held high a read is issued every cycle and the stream has no
    // bubbles. When stalled (no pop) it reduces to inflight + occ < 2, which
    // bounds the buffer at 2 entries and allows at most one read past a stall.
    assign credit_used = 3'(occ) + 3'(inflight) - 3'(pop);
    assign credit_ok   = credit_used < 3'd2;

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = buf0;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = m_axis_tvalid && (out_beat == LAST_BEAT);
    assign frame_cnt     = frame_cnt_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: FLUSH keeps reading until the current frame is fully
    // issued, then waits for the buffer and in-flight read to drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!enable) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (enable) begin
                    state_d = S_ACTIVE;
                end else if (rd_beat == '0 && occ == 2'd0 && !inflight) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: read strobe and busy flag.
    always_comb begin
        fifo_rd_en = 1'b0;
        busy       = (state_q != S_IDLE);
        if (!fifo_empty && credit_ok) begin
            if (state_q == S_ACTIVE) begin
                fifo_rd_en = 1'b1;
            end else if (state_q == S_FLUSH && rd_beat != '0) begin
                fifo_rd_en = 1'b1;
            end
        end
    end

    // Read tracking: in-flight flag and issued-read beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            rd_beat  <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (fifo_rd_en) begin
                rd_beat <= (rd_beat == LAST_BEAT) ? '0 : rd_beat + 1'b1;
            end
        end
    end

    // Output side: beat position in frame and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_beat    <= '0;
            frame_cnt_q <= '0;
        end else if (pop) begin
            out_beat <= (out_beat == LAST_BEAT) ? '0 : out_beat + 1'b1;
            if (m_axis_tlast) frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    // Skid buffer: buf0 is the head, buf1 the second entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0 <= '0;
            buf1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= fifo_dout;
                    else             buf1 <= fifo_dout;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Credit keeps occ at 1 here; the pushed word becomes head.
                    buf0 <= (occ == 2'd1) ? fifo_dout : buf1;
                    if (occ == 2'd2) buf1 <= fifo_dout;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
